// File: rtl/reg_write_arbiter.sv
// Round-robin register-file write arbiter with a two-beat PCLINK (LR then PC) sequence.
module reg_write_arbiter #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned ALU_STATUS_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][3:0]       req_sel,
    input  logic [NREQ-1:0][1:0]       req_mask,
    input  logic [NREQ-1:0][31:0]      req_data,
    input  logic [31:0]                pc_cur,
    input  logic                       mode,
    output logic                       rf_we,
    output logic [3:0]                 rf_sel,
    output logic [31:0]                rf_data,
    output logic [31:0]                rf_wmask,
    output logic                       busy
);

    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CAND_W = PTR_W + 1;

    // reg_e encoding: R0..R11 = 0..11, then the special targets
    localparam logic [3:0] SEL_STATUS = 4'd12;
    localparam logic [3:0] SEL_LR     = 4'd13;
    localparam logic [3:0] SEL_PC     = 4'd14;
    localparam logic [3:0] SEL_PCLINK = 4'd15;

    // cpu_mode_e: 1 = USER
    localparam logic MODE_USER = 1'b1;

    localparam logic [31:0] ALL_ONES          = 32'hFFFF_FFFF;
    localparam logic [31:0] STATUS_FIELD_MASK =
        32'(((64'd1 << ALU_STATUS_W) - 64'd1) << 2);

    typedef enum logic {
        IDLE = 1'b0,
        LINK = 1'b1
    } state_e;

    // reg_mask_e decode
    function automatic logic [31:0] mask_of(input logic [1:0] code);
        logic [31:0] m;
        case (code)
            2'd0:    m = 32'h0000_00FF;
            2'd1:    m = 32'h0000_FFFF;
            2'd2:    m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               rf_we_q, rf_we_d;
    logic [3:0]         rf_sel_q, rf_sel_d;
    logic [31:0]        rf_data_q, rf_data_d;
    logic [31:0]        rf_wmask_q, rf_wmask_d;
    logic [31:0]        link_data_q, link_data_d;
    logic [31:0]        link_mask_q, link_mask_d;

    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [CAND_W-1:0]  cand;
    logic [3:0]         gnt_sel;
    logic [31:0]        gnt_mask;
    logic [31:0]        gnt_data;

    // Round-robin search from ptr; no grants while the PC beat is pending
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        if (state_q == IDLE) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = CAND_W'(ptr_q) + CAND_W'(k);
                if (cand >= CAND_W'(NREQ)) begin
                    cand = cand - CAND_W'(NREQ);
                end
                if (!gnt_any && req_valid[cand[PTR_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[PTR_W-1:0];
                end
            end
            if (gnt_any) begin
                req_ready[gnt_idx] = 1'b1;
            end
        end
    end

    // Payload of the granted requester only
    always_comb begin
        gnt_sel  = req_sel[gnt_idx];
        gnt_mask = mask_of(req_mask[gnt_idx]);
        gnt_data = req_data[gnt_idx] & mask_of(req_mask[gnt_idx]);
    end

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rf_we_d     = 1'b0;
        rf_sel_d    = rf_sel_q;
        rf_data_d   = rf_data_q;
        rf_wmask_d  = rf_wmask_q;
        link_data_d = link_data_q;
        link_mask_d = link_mask_q;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                    rf_we_d = 1'b1;
                    if (gnt_sel == SEL_PCLINK) begin
                        rf_sel_d    = SEL_LR;
                        rf_data_d   = pc_cur;
                        rf_wmask_d  = ALL_ONES;
                        link_data_d = gnt_data;
                        link_mask_d = gnt_mask;
                        state_d     = LINK;
                    end else begin
                        rf_sel_d   = gnt_sel;
                        rf_data_d  = gnt_data;
                        rf_wmask_d = gnt_mask;
                        if (gnt_sel == SEL_STATUS && mode == MODE_USER) begin
                            rf_wmask_d = gnt_mask & STATUS_FIELD_MASK;
                        end
                    end
                end
            end
            LINK: begin
                rf_we_d    = 1'b1;
                rf_sel_d   = SEL_PC;
                rf_data_d  = link_data_q;
                rf_wmask_d = link_mask_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_sel_q    <= '0;
            rf_data_q   <= '0;
            rf_wmask_q  <= '0;
            link_data_q <= '0;
            link_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rf_we_q     <= rf_we_d;
            rf_sel_q    <= rf_sel_d;
            rf_data_q   <= rf_data_d;
            rf_wmask_q  <= rf_wmask_d;
            link_data_q <= link_data_d;
            link_mask_q <= link_mask_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_sel   = rf_sel_q;
    assign rf_data  = rf_data_q;
    assign rf_wmask = rf_wmask_q;
    assign busy     = (state_q == LINK);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: queue-based write model plus directed literal checks.
module tb_reg_write_arbiter;

    localparam int NREQ = 3;

    localparam logic [3:0] R_STATUS = 4'd12;
    localparam logic [3:0] R_LR     = 4'd13;
    localparam logic [3:0] R_PC     = 4'd14;
    localparam logic [3:0] R_PCLINK = 4'd15;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][3:0]  req_sel;
    logic [NREQ-1:0][1:0]  req_mask;
    logic [NREQ-1:0][31:0] req_data;
    logic [31:0]           pc_cur;
    logic                  mode;
    logic                  rf_we;
    logic [3:0]            rf_sel;
    logic [31:0]           rf_data;
    logic [31:0]           rf_wmask;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;

    reg_write_arbiter #(.NREQ(3), .ALU_STATUS_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_mask  (req_mask),
        .req_data  (req_data),
        .pc_cur    (pc_cur),
        .mode      (mode),
        .rf_we     (rf_we),
        .rf_sel    (rf_sel),
        .rf_data   (rf_data),
        .rf_wmask  (rf_wmask),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] wmask;
    } wr_t;

    wr_t         pend[$];
    int          m_ptr;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_data;
    logic [31:0] m_wmask;

    function automatic logic [31:0] code_mask(input logic [1:0] c);
        case (c)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Winner under round-robin, or -1; nobody wins while a write beat is still queued
    function automatic int m_grant(input logic [NREQ-1:0] v, input int p, input bit blocked);
        if (blocked) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            m_ptr   = 0;
            m_we    = 1'b0;
            m_sel   = '0;
            m_data  = '0;
            m_wmask = '0;
        end else begin
            int g;
            g = m_grant(req_valid, m_ptr, pend.size() != 0);
            if (g >= 0) begin
                logic [31:0] mk;
                wr_t w;
                m_ptr = (g + 1) % NREQ;
                mk = code_mask(req_mask[g]);
                if (req_sel[g] == R_PCLINK) begin
                    w.sel = R_LR; w.data = pc_cur; w.wmask = 32'hFFFF_FFFF;
                    pend.push_back(w);
                    w.sel = R_PC; w.data = req_data[g] & mk; w.wmask = mk;
                    pend.push_back(w);
                end else begin
                    w.sel = req_sel[g]; w.data = req_data[g] & mk; w.wmask = mk;
                    if (req_sel[g] == R_STATUS && mode) w.wmask = mk & 32'h0000_003C;
                    pend.push_back(w);
                end
            end
            if (pend.size() != 0) begin
                wr_t w;
                w = pend.pop_front();
                m_we = 1'b1; m_sel = w.sel; m_data = w.data; m_wmask = w.wmask;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            int g;
            logic [NREQ-1:0] er;
            g = m_grant(req_valid, m_ptr, pend.size() != 0);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("m_req_ready", 32'(req_ready), 32'(er));
            chk("m_busy",      32'(busy),      32'(pend.size() != 0));
            chk("m_rf_we",     32'(rf_we),     32'(m_we));
            chk("m_rf_sel",    32'(rf_sel),    32'(m_sel));
            chk("m_rf_data",   rf_data,        m_data);
            chk("m_rf_wmask",  rf_wmask,       m_wmask);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_sel   = '0;
        req_mask  = '0;
        req_data  = '0;
        pc_cur    = '0;
        mode      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_rf_sel",   32'(rf_sel),   32'd0);
        chk("rst_rf_data",  rf_data,       32'd0);
        chk("rst_rf_wmask", rf_wmask,      32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Requester 1 writes R3 with LS8 on the first edge after reset release
        req_valid   = 3'b010;
        req_sel[1]  = 4'd3;
        req_mask[1] = 2'd0;
        req_data[1] = 32'h1234_5678;
        req_data[0] = 32'hDEAD_BEEF;
        req_sel[0]  = R_PCLINK;
        #1;
        chk("r1_ready", 32'(req_ready), 32'b010);
        step();
        chk("r1_we",    32'(rf_we),  32'd1);
        chk("r1_sel",   32'(rf_sel), 32'd3);
        chk("r1_data",  rf_data,     32'h0000_0078);
        chk("r1_wmask", rf_wmask,    32'h0000_00FF);
        req_valid = '0;
        step();
        chk("idle_we",   32'(rf_we), 32'd0);
        chk("idle_hold", rf_data,    32'h0000_0078);

        // All three requesters valid: strict rotation from 0
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_sel[i]  = 4'(i);
            req_mask[i] = 2'd3;
            req_data[i] = 32'h1111_1111 * 32'(i + 1);
        end
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [NREQ-1:0] exp_r;
            exp_r = 3'b001 << (k % 3);
            chk("rr_ready", 32'(req_ready), 32'(exp_r));
            step();
            chk("rr_we",  32'(rf_we),  32'd1);
            chk("rr_sel", 32'(rf_sel), 32'(k % 3));
        end

        // PCLINK: LR beat then PC beat, no grants during LINK
        clear_inputs();
        req_valid   = 3'b001;
        req_sel[0]  = R_PCLINK;
        req_mask[0] = 2'd3;
        req_data[0] = 32'h0000_0400;
        pc_cur      = 32'h0000_0100;
        #1;
        chk("pl_ready", 32'(req_ready), 32'b001);
        step();
        pc_cur = 32'h0000_0999;
        req_valid = 3'b111;
        #1;
        chk("pl_lr_we",    32'(rf_we),     32'd1);
        chk("pl_lr_sel",   32'(rf_sel),    32'(R_LR));
        chk("pl_lr_data",  rf_data,        32'h0000_0100);
        chk("pl_lr_wmask", rf_wmask,       32'hFFFF_FFFF);
        chk("pl_busy",     32'(busy),      32'd1);
        chk("pl_noready",  32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        chk("pl_pc_we",    32'(rf_we),  32'd1);
        chk("pl_pc_sel",   32'(rf_sel), 32'(R_PC));
        chk("pl_pc_data",  rf_data,     32'h0000_0400);
        chk("pl_pc_wmask", rf_wmask,    32'hFFFF_FFFF);
        chk("pl_busy_end", 32'(busy),   32'd0);

        // STATUS write: USER restricts the bit-enable mask, SUPERVISOR does not
        clear_inputs();
        mode        = 1'b1;
        req_valid   = 3'b010;
        req_sel[1]  = R_STATUS;
        req_mask[1] = 2'd3;
        req_data[1] = 32'hFFFF_FFFF;
        step();
        chk("st_user_wmask", rf_wmask, 32'h0000_003C);
        chk("st_user_data",  rf_data,  32'hFFFF_FFFF);
        mode = 1'b0;
        step();
        chk("st_sup_wmask", rf_wmask, 32'hFFFF_FFFF);
        req_valid = '0;
        step();

        // PCLINK then requester 2 waiting during LINK: granted on the PC beat
        clear_inputs();
        req_valid   = 3'b001;
        req_sel[0]  = R_PCLINK;
        req_mask[0] = 2'd1;
        req_data[0] = 32'h5555_2000;
        pc_cur      = 32'h0000_0800;
        step();
        req_valid   = 3'b100;
        req_sel[2]  = 4'd7;
        req_mask[2] = 2'd2;
        req_data[2] = 32'hABCD_1234;
        #1;
        chk("b2_link_ready", 32'(req_ready), 32'd0);
        step();
        chk("b2_pc_sel",   32'(rf_sel),    32'(R_PC));
        chk("b2_pc_data",  rf_data,        32'h0000_2000);
        chk("b2_pc_wmask", rf_wmask,       32'h0000_FFFF);
        chk("b2_ready",    32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        chk("b2_we",    32'(rf_we),  32'd1);
        chk("b2_sel",   32'(rf_sel), 32'd7);
        chk("b2_data",  rf_data,     32'h00CD_1234);
        chk("b2_wmask", rf_wmask,    32'h00FF_FFFF);
        step();

        // Reset asserted during LINK abandons the PC beat
        clear_inputs();
        req_valid   = 3'b001;
        req_sel[0]  = R_PCLINK;
        req_mask[0] = 2'd3;
        req_data[0] = 32'h0000_7000;
        pc_cur      = 32'h0000_0300;
        step();
        req_valid = '0;
        chk("rl_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rl_we_now",   32'(rf_we),  32'd0);
        chk("rl_busy_now", 32'(busy),   32'd0);
        chk("rl_sel_now",  32'(rf_sel), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("rl_no_pc", 32'(rf_we), 32'd0);
        chk("rl_idle",  32'(busy),  32'd0);

        // Mixed traffic checked by the model each cycle
        for (int c = 0; c < 30; c++) begin
            req_valid = 3'((c * 5 + 3) % 8);
            for (int i = 0; i < NREQ; i++) begin
                req_sel[i]  = 4'((c * 3 + i * 7 + 11) % 16);
                req_mask[i] = 2'((c + i) % 4);
                req_data[i] = 32'h9E37_79B9 * 32'(c * NREQ + i + 1);
            end
            mode   = 1'(c % 2);
            pc_cur = 32'(c) * 32'h0000_0040;
            step();
        end
        clear_inputs();
        step();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
